// File: rtl/i2si_pkg.sv
// Shared constants and FSM encoding for the I2S receive master sequencer.
package i2si_pkg;

   localparam int WORD_W     = 16;
   localparam int FRAME_BITS = 32;
   localparam int BIT_W      = $clog2(FRAME_BITS);

   // Word select levels: left channel while low, right channel while high.
   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } i2si_state_e;

endpackage

// File: rtl/i2si_sfifo.sv
// Small synchronous show-ahead FIFO. A push into a full FIFO is dropped and
// reported on o_ovf, unless a pop happens in the same cycle.
module i2si_sfifo
   import i2si_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic [CW-1:0]    o_cnt,
   output logic             o_ovf
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_cnt;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CW'(DEPTH));
   // A pop frees the slot the push needs, so full+push+pop is legal.
   assign w_do_pop  = i_pop & ~w_empty;
   assign w_do_push = i_push & (~w_full | w_do_pop);

   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_cnt   = r_cnt;
   assign o_ovf   = i_push & w_full & ~w_do_pop;
   // Head entry is visible without a pop; empty reads as zero.
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array, written at the tail.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers (wrap naturally, depth is a power of two) and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/i2si_ctrl.sv
// I2S receive master: SCK/WS generation, frame-aligned deserializer enable,
// and a stereo sample FIFO draining over valid/ready.
module i2si_ctrl
   import i2si_pkg::*;
#(
   parameter  int WORD_W     = i2si_pkg::WORD_W,
   parameter  int DIV_W      = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rf_i2si_en,
   input  logic [DIV_W-1:0]    rf_i2si_div,
   input  logic                rf_i2si_clr_ovf,
   output logic                i2si_sck,
   output logic                i2si_ws,
   output logic                ctl_i2si_en,
   input  logic [WORD_W-1:0]   i2si_lft,
   input  logic [WORD_W-1:0]   i2si_rgt,
   input  logic                i2si_xfc,
   output logic [2*WORD_W-1:0] smp_data,
   output logic                smp_vld,
   input  logic                smp_rdy,
   output logic                i2si_ovf,
   output logic                i2si_busy,
   output logic [CNT_W-1:0]    fifo_cnt
);

   i2si_state_e r_state;
   i2si_state_e w_state_nxt;

   logic [DIV_W-1:0] r_div_q;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_sck;
   logic             r_ws;
   logic [BIT_W-1:0] r_bit_cnt;
   logic             r_ovf;

   logic [DIV_W-1:0] w_div_sel;
   logic             w_sck_tick;
   logic             w_sck_fall;
   logic             w_frame_end;
   logic [BIT_W-1:0] w_bit_nxt;
   logic             w_ctl_en;
   logic             w_busy;
   logic             w_empty;
   logic             w_full;
   logic             w_ovf_stb;

   // Half-periods below two clocks cannot produce a clean SCK.
   assign w_div_sel = (rf_i2si_div < DIV_W'(2)) ? DIV_W'(2) : rf_i2si_div;

   assign w_sck_tick  = (r_state != IDLE) && (r_div_cnt == '0);
   assign w_sck_fall  = w_sck_tick & r_sck;
   assign w_frame_end = w_sck_fall && (r_bit_cnt == BIT_W'(FRAME_BITS-1));
   // The falling edge closing START lands on the last bit of a frame so the
   // first real frame begins cleanly at bit 0.
   assign w_bit_nxt   = (r_state == START) ? BIT_W'(FRAME_BITS-1)
                                           : r_bit_cnt + BIT_W'(1);

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // FSM next-state: stopping is deferred to the frame boundary.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (rf_i2si_en) w_state_nxt = START;
         START:   if (w_sck_fall) w_state_nxt = RUN;
         RUN:     if (!rf_i2si_en) w_state_nxt = STOP;
         STOP: begin
            if (rf_i2si_en)       w_state_nxt = RUN;
            else if (w_frame_end) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs: deserializer runs whenever the sequencer is active.
   always_comb begin
      w_ctl_en = (r_state != IDLE);
      w_busy   = (r_state != IDLE);
   end

   // SCK divider: each SCK phase lasts exactly div_q clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_q   <= '0;
         r_div_cnt <= '0;
         r_sck     <= 1'b0;
      end else if (r_state == IDLE) begin
         r_sck     <= 1'b0;
         r_div_cnt <= '0;
         if (rf_i2si_en) begin
            r_div_q   <= w_div_sel;
            r_div_cnt <= w_div_sel - DIV_W'(1);
         end
      end else if (w_state_nxt == IDLE) begin
         r_sck     <= 1'b0;
         r_div_cnt <= '0;
      end else if (w_sck_tick) begin
         r_sck     <= ~r_sck;
         r_div_cnt <= r_div_q - DIV_W'(1);
      end else begin
         r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
   end

   // Bit counter and WS: WS flips one bit ahead of each channel MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
         r_ws      <= WS_RIGHT;
      end else if (r_state == IDLE) begin
         r_bit_cnt <= '0;
         r_ws      <= WS_RIGHT;
      end else if (w_sck_fall) begin
         r_bit_cnt <= w_bit_nxt;
         if (w_state_nxt == IDLE)
            r_ws <= WS_RIGHT;
         else if (w_bit_nxt == BIT_W'(FRAME_BITS-1))
            r_ws <= WS_LEFT;
         else if (w_bit_nxt == BIT_W'(FRAME_BITS/2-1))
            r_ws <= WS_RIGHT;
      end
   end

   i2si_sfifo #(
      .WIDTH (2*WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i2si_xfc),
      .i_data  ({i2si_lft, i2si_rgt}),
      .i_pop   (smp_rdy),
      .o_data  (smp_data),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_cnt   (fifo_cnt),
      .o_ovf   (w_ovf_stb)
   );

   // Sticky overflow: a fresh overflow beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 r_ovf <= 1'b0;
      else if (w_ovf_stb)       r_ovf <= 1'b1;
      else if (rf_i2si_clr_ovf) r_ovf <= 1'b0;
   end

   assign i2si_sck    = r_sck;
   assign i2si_ws     = r_ws;
   assign ctl_i2si_en = w_ctl_en;
   assign i2si_busy   = w_busy;
   assign smp_vld     = ~w_empty;
   assign i2si_ovf    = r_ovf;

endmodule

// File: tb/tb_i2si_ctrl.sv
// Self-checking bench for i2si_ctrl: idle/reset, SCK/WS frame timing,
// stop at frame boundary, FIFO show-ahead/overflow, async reset mid-frame.
module tb_i2si_ctrl;

   localparam int WORD_W = 16;
   localparam int DIV_W  = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                rf_i2si_en = 1'b0;
   logic [DIV_W-1:0]    rf_i2si_div = 8'd4;
   logic                rf_i2si_clr_ovf = 1'b0;
   logic                i2si_sck, i2si_ws, ctl_i2si_en;
   logic [WORD_W-1:0]   i2si_lft = '0;
   logic [WORD_W-1:0]   i2si_rgt = '0;
   logic                i2si_xfc = 1'b0;
   logic [2*WORD_W-1:0] smp_data;
   logic                smp_vld;
   logic                smp_rdy = 1'b0;
   logic                i2si_ovf, i2si_busy;
   logic [CNT_W-1:0]    fifo_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2si_ctrl #(.WORD_W(WORD_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rf_i2si_en(rf_i2si_en), .rf_i2si_div(rf_i2si_div),
      .rf_i2si_clr_ovf(rf_i2si_clr_ovf), .i2si_sck(i2si_sck), .i2si_ws(i2si_ws),
      .ctl_i2si_en(ctl_i2si_en), .i2si_lft(i2si_lft), .i2si_rgt(i2si_rgt),
      .i2si_xfc(i2si_xfc), .smp_data(smp_data), .smp_vld(smp_vld), .smp_rdy(smp_rdy),
      .i2si_ovf(i2si_ovf), .i2si_busy(i2si_busy), .fifo_cnt(fifo_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_line(input string tag, input logic e_sck, input logic e_ws, input logic e_act);
      chk({tag, ".sck"}, 64'(i2si_sck), 64'(e_sck));
      chk({tag, ".ws"}, 64'(i2si_ws), 64'(e_ws));
      chk({tag, ".ctl_en"}, 64'(ctl_i2si_en), 64'(e_act));
      chk({tag, ".busy"}, 64'(i2si_busy), 64'(e_act));
   endtask

   // Frame timing model. j counts clocks since the enable was accepted.
   // SCK: low for d clocks then high for d clocks, repeating from j=0.
   // Falling edges at j=2d*p; p=1 closes the sync period on bit 31, then
   // p counts bits so bit=(p+30)%32. WS is high on bits 15..30.
   // Shutdown happens on the first frame wrap (p=2+32q) after RUN saw en=0.
   task automatic run_seq(input int dsel, input int td1, input int tr, input int td2,
                          input bit rnd_div);
      int d, off, js, jw, p, b;
      logic e_sck, e_ws, e_act;
      d   = (dsel < 2) ? 2 : dsel;
      off = (tr != 0) ? td2 : td1;
      js  = (off > 2*d+1) ? off : 2*d+1;
      jw  = 4*d;
      while (jw <= js) jw += 64*d;
      rf_i2si_div = DIV_W'(dsel);
      rf_i2si_en  = 1'b1;
      tick();
      chk_line("start", 1'b0, 1'b1, 1'b1);
      for (int j = 1; j <= jw + 2; j++) begin
         rf_i2si_en = (j < td1) || (tr != 0 && j >= tr && j < td2);
         if (rnd_div) rf_i2si_div = DIV_W'($urandom_range(0, 255));
         tick();
         if (j >= jw) begin
            e_sck = 1'b0; e_ws = 1'b1; e_act = 1'b0;
         end else begin
            p     = j / (2*d);
            e_sck = ((j / d) % 2) == 1;
            e_act = 1'b1;
            if (p == 0) e_ws = 1'b1;
            else begin
               b    = (p + 30) % 32;
               e_ws = (b >= 15) && (b <= 30);
            end
         end
         chk_line("frame", e_sck, e_ws, e_act);
      end
   endtask

   typedef struct {
      logic        push;
      logic [31:0] din;
      logic        rdy;
      logic        clr;
      logic        e_vld;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
      logic        e_ovf;
   } vec_t;

   vec_t tv[17];

   initial begin
      logic [31:0] q[$];
      logic        m_ovf, pu, rd, cl, set;
      logic [31:0] dn;
      int          d, t;

      // Reset and idle
      #20;
      chk_line("rst", 1'b0, 1'b1, 1'b0);
      chk("rst.vld", 64'(smp_vld), 64'd0);
      chk("rst.data", 64'(smp_data), 64'd0);
      chk("rst.cnt", 64'(fifo_cnt), 64'd0);
      chk("rst.ovf", 64'(i2si_ovf), 64'd0);
      #30 rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk_line("idle", 1'b0, 1'b1, 1'b0);
         chk("idle.vld", 64'(smp_vld), 64'd0);
         chk("idle.cnt", 64'(fifo_cnt), 64'd0);
      end

      // FIFO table: fill, overflow, clear, full push+pop, set-beats-clear, drain
      tv[0]  = '{1'b1, 32'hAAAAFF00, 1'b0, 1'b0, 1'b1, 32'hAAAAFF00, 3'd1, 1'b0};
      tv[1]  = '{1'b1, 32'h11112222, 1'b0, 1'b0, 1'b1, 32'hAAAAFF00, 3'd2, 1'b0};
      tv[2]  = '{1'b1, 32'h33334444, 1'b0, 1'b0, 1'b1, 32'hAAAAFF00, 3'd3, 1'b0};
      tv[3]  = '{1'b1, 32'h55556666, 1'b0, 1'b0, 1'b1, 32'hAAAAFF00, 3'd4, 1'b0};
      tv[4]  = '{1'b1, 32'h77778888, 1'b0, 1'b0, 1'b1, 32'hAAAAFF00, 3'd4, 1'b1};
      tv[5]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'hAAAAFF00, 3'd4, 1'b0};
      tv[6]  = '{1'b1, 32'h9999AAAA, 1'b1, 1'b0, 1'b1, 32'h11112222, 3'd4, 1'b0};
      tv[7]  = '{1'b1, 32'hBBBBCCCC, 1'b0, 1'b0, 1'b1, 32'h11112222, 3'd4, 1'b1};
      tv[8]  = '{1'b1, 32'hDDDDEEEE, 1'b0, 1'b1, 1'b1, 32'h11112222, 3'd4, 1'b1};
      tv[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h11112222, 3'd4, 1'b0};
      tv[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h33334444, 3'd3, 1'b0};
      tv[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h55556666, 3'd2, 1'b0};
      tv[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h9999AAAA, 3'd1, 1'b0};
      tv[13] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0};
      tv[14] = '{1'b1, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, 32'h0F0F0F0F, 3'd1, 1'b0};
      tv[15] = '{1'b1, 32'hF0F0F0F0, 1'b1, 1'b0, 1'b1, 32'hF0F0F0F0, 3'd1, 1'b0};
      tv[16] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0};
      for (int i = 0; i < 17; i++) begin
         i2si_xfc = tv[i].push;
         i2si_lft = tv[i].din[31:16];
         i2si_rgt = tv[i].din[15:0];
         smp_rdy  = tv[i].rdy;
         rf_i2si_clr_ovf = tv[i].clr;
         tick();
         i2si_xfc = 1'b0; smp_rdy = 1'b0; rf_i2si_clr_ovf = 1'b0;
         chk($sformatf("tv%0d.vld", i), 64'(smp_vld), 64'(tv[i].e_vld));
         chk($sformatf("tv%0d.cnt", i), 64'(fifo_cnt), 64'(tv[i].e_cnt));
         chk($sformatf("tv%0d.ovf", i), 64'(i2si_ovf), 64'(tv[i].e_ovf));
         if (tv[i].e_vld) chk($sformatf("tv%0d.data", i), 64'(smp_data), 64'(tv[i].e_data));
      end

      // Random FIFO traffic against a queue model
      m_ovf = 1'b0;
      for (int i = 0; i < 400; i++) begin
         pu = ($urandom_range(0, 2) != 0);
         rd = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cl = ($urandom_range(0, 15) == 0);
         dn = $urandom;
         i2si_xfc = pu; i2si_lft = dn[31:16]; i2si_rgt = dn[15:0];
         smp_rdy = rd; rf_i2si_clr_ovf = cl;
         tick();
         if (rd && q.size() > 0) void'(q.pop_front());
         set = 1'b0;
         if (pu) begin
            if (q.size() < DEPTH) q.push_back(dn);
            else set = 1'b1;
         end
         if (set) m_ovf = 1'b1;
         else if (cl) m_ovf = 1'b0;
         chk("rnd.vld", 64'(smp_vld), 64'(q.size() > 0));
         chk("rnd.cnt", 64'(fifo_cnt), 64'(q.size()));
         chk("rnd.ovf", 64'(i2si_ovf), 64'(m_ovf));
         if (q.size() > 0) chk("rnd.data", 64'(smp_data), 64'(q[0]));
      end
      i2si_xfc = 1'b0; rf_i2si_clr_ovf = 1'b0;
      smp_rdy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      smp_rdy = 1'b0;
      chk("drain.cnt", 64'(fifo_cnt), 64'd0);

      // Timing: div=4, drop at bit 7, stop at the next frame wrap
      run_seq(4, 73, 0, 0, 1'b0);
      // Re-assert during STOP at bit 20: no gap, final drop later
      run_seq(4, 73, 176, 300, 1'b1);
      // Divider below minimum clamps to 2
      run_seq(1, 30, 0, 0, 1'b1);
      // Random divider values and stop points
      for (int r = 0; r < 6; r++) begin
         t = $urandom_range(0, 6);
         d = (t < 2) ? 2 : t;
         run_seq(t, $urandom_range(1, 2*d*40), 0, 0, 1'b1);
      end

      // Async reset mid-frame at bit 20 with two samples queued
      rf_i2si_div = 8'd4;
      rf_i2si_en  = 1'b1;
      tick();
      for (int j = 1; j <= 180; j++) begin
         i2si_xfc = (j == 10) || (j == 20);
         i2si_lft = 16'(j);
         i2si_rgt = 16'(j * 3);
         tick();
      end
      i2si_xfc = 1'b0;
      chk("arst.pre_cnt", 64'(fifo_cnt), 64'd2);
      chk("arst.pre_busy", 64'(i2si_busy), 64'd1);
      #3 rst = 1'b0;
      #1;
      chk_line("arst", 1'b0, 1'b1, 1'b0);
      chk("arst.vld", 64'(smp_vld), 64'd0);
      chk("arst.data", 64'(smp_data), 64'd0);
      chk("arst.cnt", 64'(fifo_cnt), 64'd0);
      chk("arst.ovf", 64'(i2si_ovf), 64'd0);
      rf_i2si_en = 1'b0;
      #2 rst = 1'b1;
      tick();
      chk_line("post", 1'b0, 1'b1, 1'b0);
      chk("post.cnt", 64'(fifo_cnt), 64'd0);
      chk("post.vld", 64'(smp_vld), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/i2si_ctrl.md
Name: i2si_ctrl

Overview:
- Master-mode sequencer for the i2si_deserializer.
- Generates i2si_sck and i2si_ws from the system clock using a programmable divider.
- Drives the deserializer enable so capture starts and stops only on frame boundaries.
- Collects each stereo sample (i2si_lft/i2si_rgt on an i2si_xfc pulse) into a small FIFO that drains through a valid/ready handshake to the audio datapath.

Parameters:
- WORD_W, 16, bits per channel word.
- DIV_W, 8, width of the SCK half-period divider.
- FIFO_DEPTH, 4, stereo sample entries; must be a power of 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- rf_i2si_en  in  1  run request, level.
- rf_i2si_div  in  DIV_W  SCK half-period in clk cycles.
- rf_i2si_clr_ovf  in  1  single-cycle pulse; clears i2si_ovf.
- i2si_sck  out  1  serial clock to codec and deserializer.
- i2si_ws  out  1  word select; 0 = left, 1 = right.
- ctl_i2si_en  out  1  to deserializer rf_i2si_en.
- i2si_lft  in  WORD_W  left word from deserializer.
- i2si_rgt  in  WORD_W  right word from deserializer.
- i2si_xfc  in  1  one-clk pulse: stereo pair valid.
- smp_data  out  2*WORD_W  {lft,rgt} at FIFO head.
- smp_vld  out  1  FIFO non-empty.
- smp_rdy  in  1  consumer accepts the head entry.
- i2si_ovf  out  1  sticky overflow flag.
- i2si_busy  out  1  FSM not in IDLE.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset values (rst=0, async): FSM=IDLE, i2si_sck=0, i2si_ws=1, ctl_i2si_en=0, FIFO empty, smp_vld=0, smp_data=0, i2si_ovf=0, i2si_busy=0, fifo_cnt=0, divider and bit counters=0. Asserting reset mid-frame aborts immediately; no partial sample is pushed.
- FSM states: IDLE, START, RUN, STOP.
- IDLE:
  - sck=0, ws=1.
  - rf_i2si_en=1 -> START; latch div_q = max(rf_i2si_div, 2).
  - rf_i2si_div is sampled only on this transition; later changes are ignored until the next START.
- START:
  - ctl_i2si_en=1, ws=1.
  - Runs one full SCK period (2*div_q clk) for deserializer sync, then -> RUN with bit_cnt=31.
- Divider:
  - Counter reloads div_q-1 and counts down.
  - At 0, sck toggles and the counter reloads.
  - sck high and low phases are each exactly div_q clk.
- bit_cnt (0..31):
  - Increments mod 32 on each sck falling edge (1->0) in RUN/STOP.
  - On the same falling edge, ws updates: ws<=0 when the new bit_cnt=31, ws<=1 when the new bit_cnt=15.
  - WS therefore leads each channel MSB by one bit (I2S).
- RUN -> STOP when rf_i2si_en=0.
- STOP:
  - Continues clocking until the falling edge where bit_cnt wraps 31->0, then -> IDLE.
  - Entering IDLE sets ctl_i2si_en=0, sck=0, ws=1.
  - rf_i2si_en re-asserted during STOP: return to RUN, no gap.
- ctl_i2si_en=1 and i2si_busy=1 in START, RUN, STOP.
- FIFO push/pop:
  - Push {i2si_lft,i2si_rgt} on i2si_xfc=1, in any state.
  - Pop when smp_vld & smp_rdy.
  - Show-ahead: smp_data is the head entry; latency i2si_xfc -> smp_vld = 1 clk when empty.
- FIFO boundaries:
  - Full, push, no pop: sample dropped, i2si_ovf<=1.
  - Full, push and pop in the same cycle: both performed, no overflow.
  - Empty, pop: impossible, since smp_vld=0.
  - Pointers wrap mod FIFO_DEPTH.
- Overflow flag: rf_i2si_clr_ovf clears it. If clear and a new overflow occur in the same cycle, set wins.
- fifo_cnt reflects the registered occupancy after each clk.

Decomposition:
- Package i2si_pkg: WORD_W, FRAME_BITS=32, WS_LEFT=0, WS_RIGHT=1, FSM state encoding (IDLE=0, START=1, RUN=2, STOP=3).
- Sub-module i2si_sfifo: synchronous FIFO with show-ahead, full/empty, count, and overflow strobe, parameterized by width and depth.
- Divider, bit counter and FSM stay in i2si_ctrl.

Test Plan:
- Reset and idle: rst low 50 ns then high, rf_i2si_en=0 -> sck=0, ws=1, ctl_i2si_en=0, smp_vld=0, fifo_cnt=0 for 1 us.
- Timing: rf_i2si_div=4, rf_i2si_en=1 -> START lasts 8 clk; sck period 8 clk; ws falls at the falling edge entering bit 31, rises 16 sck later; one frame = 256 clk.
- Capture: codec model sends L=16'hAAAA, R=16'hFF00 into a real deserializer -> smp_data=32'hAAAAFF00, smp_vld 1 clk after i2si_xfc; pop with smp_rdy=1 -> fifo_cnt 1->0.
- Overflow: smp_rdy=0, 5 i2si_xfc pulses -> fifo_cnt=4, i2si_ovf=1, head = first sample. Then push and pop in the same cycle while full -> no extra overflow. Then rf_i2si_clr_ovf -> i2si_ovf=0.
- Stop: drop rf_i2si_en at bit 7 -> clocking continues to bit 31->0 wrap, then ctl_i2si_en=0, sck=0, ws=1. Re-assert during STOP -> stays RUN.
- Async reset mid-frame: rst low at bit 20 with fifo_cnt=2 -> all outputs at reset values within the same clk, FIFO empty.
